// File: rtl/sd_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_pkg
//  Description : Shared widths, transfer modes and engine state encoding
//                for the SD-card SPI datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package sd_spi_pkg;

   localparam int RXLEN_W = 13;
   localparam int DIV_W   = 8;

   localparam logic [1:0] MODE_TX   = 2'd0;
   localparam logic [1:0] MODE_RX   = 2'd1;
   localparam logic [1:0] MODE_XFER = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   // The reserved mode code behaves exactly like write-only.
   function automatic logic [1:0] eff_mode(input logic [1:0] m);
      return ((m == MODE_RX) || (m == MODE_XFER)) ? m : MODE_TX;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_half_period_timer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_half_period_timer
//  Description : Reloading down-counter. After a load of N, expire pulses on
//                every (N+1)th cycle until the next load.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_half_period_timer #(
   parameter int DIV_W = 8
) (
   input  logic             C100M,
   input  logic             RESET_n,
   input  logic             load,
   input  logic [DIV_W-1:0] value,
   output logic             expire
);

   logic [DIV_W-1:0] r_reload;
   logic [DIV_W-1:0] r_cnt;

   // Count down to zero, then restart from the most recently loaded value.
   always_ff @(posedge C100M or negedge RESET_n) begin
      if (!RESET_n) begin
         r_reload <= '0;
         r_cnt    <= '0;
      end else if (load) begin
         r_reload <= value;
         r_cnt    <= value;
      end else if (r_cnt == '0) begin
         r_cnt    <= r_reload;
      end else begin
         r_cnt    <= r_cnt - 1'b1;
      end
   end

   assign expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/spi_byte_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_byte_shifter
//  Description : SPI mode-0 byte engine between the SD controller TX and RX
//                FIFOs. Write-only, counted autonomous read (0xFF clocked
//                out) and full-duplex transfers, MSB first.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_byte_shifter #(
   parameter int RXLEN_W = sd_spi_pkg::RXLEN_W,
   parameter int DIV_W   = sd_spi_pkg::DIV_W
) (
   input  logic               C100M,
   input  logic               RESET_n,
   input  logic [DIV_W-1:0]   clk_div,
   input  logic [1:0]         mode,
   input  logic [RXLEN_W-1:0] new_rx_length,
   input  logic               set_rx_length,
   input  logic               wr_req,
   input  logic [7:0]         data_in,
   input  logic               rd_req,
   output logic [7:0]         data_out,
   output logic               in_full,
   output logic               out_full,
   output logic               busy,
   input  logic               MISO,
   output logic               MOSI,
   output logic               SCLK
);

   import sd_spi_pkg::*;

   state_t             r_state;
   logic               r_sclk;
   logic               r_mosi;
   logic [7:0]         r_shift;
   logic [2:0]         r_bitcnt;
   logic [1:0]         r_mode;
   logic [7:0]         r_hold;
   logic               r_in_full;
   logic [7:0]         r_data_out;
   logic               r_out_full;
   logic [RXLEN_W-1:0] r_rx_rem;

   logic               w_expire;
   logic [1:0]         w_mode_req;
   logic               w_byte_done;
   logic               w_fill;
   logic               w_slot_free;
   logic               w_rx_pending;
   logic               w_start_ok;
   logic               w_start;
   logic [7:0]         w_start_byte;

   spi_half_period_timer #(
      .DIV_W   (DIV_W)
   ) u_timer (
      .C100M   (C100M),
      .RESET_n (RESET_n),
      .load    (w_start),
      .value   (clk_div),
      .expire  (w_expire)
   );

   assign w_mode_req   = eff_mode(mode);
   assign w_byte_done  = (r_state == HIGH) && w_expire && (r_bitcnt == 3'd0);
   // A receiving byte that completes this cycle occupies the output slot, so
   // the next receiving byte has to wait for the consumer: this is what makes
   // an overrun impossible.
   assign w_fill       = w_byte_done && (r_mode != MODE_TX);
   assign w_slot_free  = !w_fill && (!r_out_full || rd_req);
   assign w_rx_pending = (r_rx_rem != '0);
   assign w_start_byte = (w_mode_req == MODE_RX) ? 8'hFF : r_hold;

   // Byte start condition for the mode currently requested.
   always_comb begin
      w_start_ok = 1'b0;
      case (w_mode_req)
         MODE_RX:   w_start_ok = w_rx_pending && w_slot_free;
         MODE_XFER: w_start_ok = r_in_full && w_slot_free;
         default:   w_start_ok = r_in_full;
      endcase
   end

   assign w_start = ((r_state == IDLE) || w_byte_done) && w_start_ok;

   // Bit engine: LOW phase, rising edge samples MISO, HIGH phase, falling edge
   // shifts out the next bit; a new byte may start on the last falling edge.
   always_ff @(posedge C100M or negedge RESET_n) begin
      if (!RESET_n) begin
         r_state  <= IDLE;
         r_sclk   <= 1'b0;
         r_mosi   <= 1'b1;
         r_shift  <= 8'h00;
         r_bitcnt <= 3'd0;
         r_mode   <= MODE_TX;
      end else if (w_start) begin
         r_state  <= LOW;
         r_sclk   <= 1'b0;
         r_mosi   <= w_start_byte[7];
         r_shift  <= w_start_byte;
         r_bitcnt <= 3'd7;
         r_mode   <= w_mode_req;
      end else begin
         case (r_state)
            LOW: begin
               if (w_expire) begin
                  r_sclk  <= 1'b1;
                  r_shift <= {r_shift[6:0], MISO};
                  r_state <= HIGH;
               end
            end
            HIGH: begin
               if (w_expire) begin
                  r_sclk <= 1'b0;
                  if (r_bitcnt != 3'd0) begin
                     r_mosi   <= r_shift[7];
                     r_bitcnt <= r_bitcnt - 3'd1;
                     r_state  <= LOW;
                  end else begin
                     r_mosi   <= 1'b1;
                     r_state  <= IDLE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // TX holding register: filled by the upstream FIFO, emptied by a byte start.
   always_ff @(posedge C100M or negedge RESET_n) begin
      if (!RESET_n) begin
         r_in_full <= 1'b0;
         r_hold    <= 8'h00;
      end else if (w_start && (w_mode_req != MODE_RX)) begin
         r_in_full <= 1'b0;
      end else if (wr_req && !r_in_full) begin
         r_in_full <= 1'b1;
         r_hold    <= data_in;
      end
   end

   // RX output slot: a completing receive byte wins over a concurrent read.
   always_ff @(posedge C100M or negedge RESET_n) begin
      if (!RESET_n) begin
         r_out_full <= 1'b0;
         r_data_out <= 8'h00;
      end else if (w_fill) begin
         r_out_full <= 1'b1;
         r_data_out <= r_shift;
      end else if (rd_req && r_out_full) begin
         r_out_full <= 1'b0;
      end
   end

   // Remaining autonomous-read bytes; an overwrite wins over the decrement.
   always_ff @(posedge C100M or negedge RESET_n) begin
      if (!RESET_n) begin
         r_rx_rem <= '0;
      end else if (set_rx_length) begin
         r_rx_rem <= new_rx_length;
      end else if (w_start && (w_mode_req == MODE_RX) && w_rx_pending) begin
         r_rx_rem <= r_rx_rem - 1'b1;
      end
   end

   assign SCLK     = r_sclk;
   assign MOSI     = r_mosi;
   assign data_out = r_data_out;
   assign in_full  = r_in_full;
   assign out_full = r_out_full;
   assign busy     = (r_state != IDLE) || r_in_full || ((mode == MODE_RX) && w_rx_pending);

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_byte_shifter
//  Description : Self-checking bench for spi_byte_shifter with an SPI slave
//                model and MOSI / RX-byte scoreboards.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_byte_shifter;

   logic        C100M = 1'b0;
   logic        RESET_n = 1'b0;
   logic [7:0]  clk_div;
   logic [1:0]  mode;
   logic [12:0] new_rx_length;
   logic        set_rx_length;
   logic        wr_req;
   logic [7:0]  data_in;
   logic        rd_req = 1'b0;
   logic [7:0]  data_out;
   logic        in_full;
   logic        out_full;
   logic        busy;
   logic        MISO;
   logic        MOSI;
   logic        SCLK;

   int          n_checks = 0;
   int          n_fail = 0;

   logic [7:0]  exp_mosi[$];
   logic [7:0]  exp_rx[$];

   // slave model / monitor state (written only by the monitor)
   logic [7:0]  slave_byte = 8'h00;
   logic [7:0]  cap = 8'h00;
   int          bit_cnt = 0;
   int          rises_total = 0;
   int          prev_id = 0;
   int          n_int = 0;
   int          n_bad_int = 0;
   time         last_rise = 0;
   // interval tracking controls (written only by the main sequence)
   int          track_id = 0;
   time         per_exp = 0;
   // reader state
   bit          auto_rd = 1'b0;
   int          req_tok = 0;
   int          served_tok = 0;
   int          n_reads = 0;
   int          n_infull_falls = 0;

   spi_byte_shifter dut (
      .C100M         (C100M),
      .RESET_n       (RESET_n),
      .clk_div       (clk_div),
      .mode          (mode),
      .new_rx_length (new_rx_length),
      .set_rx_length (set_rx_length),
      .wr_req        (wr_req),
      .data_in       (data_in),
      .rd_req        (rd_req),
      .data_out      (data_out),
      .in_full       (in_full),
      .out_full      (out_full),
      .busy          (busy),
      .MISO          (MISO),
      .MOSI          (MOSI),
      .SCLK          (SCLK)
   );

   always #5 C100M = ~C100M;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // slave presents the next bit before each rising edge, MSB first
   assign MISO = slave_byte[3'(7 - bit_cnt)];

   // capture MOSI on SCLK rises; measure SCLK periods inside a tracked window
   always @(posedge SCLK or negedge RESET_n) begin
      if (!RESET_n) begin
         bit_cnt = 0;
         cap     = 8'h00;
      end else begin
         rises_total++;
         if ((track_id != 0) && (prev_id == track_id)) begin
            n_int++;
            if (($time - last_rise) != per_exp) n_bad_int++;
         end
         prev_id   = track_id;
         last_rise = $time;
         cap       = {cap[6:0], MOSI};
         if (bit_cnt == 7) begin
            bit_cnt = 0;
            if (exp_mosi.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL mosi_unexpected: got %02h expected none", cap);
            end else begin
               chk("mosi_byte", cap, exp_mosi.pop_front());
            end
         end else begin
            bit_cnt++;
         end
      end
   end

   always @(negedge in_full) n_infull_falls++;

   // consumer: reads automatically or on request, checks each consumed byte
   always @(negedge C100M) begin
      rd_req = out_full && (auto_rd || (req_tok != served_tok));
      if (rd_req) begin
         served_tok = req_tok;
         n_reads++;
         if (exp_rx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: got %02h expected none", data_out);
         end else begin
            chk("rx_byte", data_out, exp_rx.pop_front());
         end
      end
   end

   task automatic write_byte(input logic [7:0] d, input bit with_rx);
      int guard = 0;
      @(negedge C100M);
      while (in_full && guard < 5000) begin
         @(negedge C100M);
         guard++;
      end
      if (in_full) chk("wr_timeout", in_full, 1'b0);
      wr_req  = 1'b1;
      data_in = d;
      exp_mosi.push_back(d);
      if (with_rx) exp_rx.push_back(slave_byte);
      @(negedge C100M);
      wr_req  = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      @(negedge C100M);
      while (busy && n < bound) begin
         @(negedge C100M);
         n++;
      end
      chk("idle_wait", busy, 1'b0);
   endtask

   task automatic wait_out_full(input logic val, input int bound);
      int n = 0;
      @(negedge C100M);
      while ((out_full != val) && n < bound) begin
         @(negedge C100M);
         n++;
      end
      chk("out_full_wait", out_full, val);
   endtask

   task automatic set_length(input logic [12:0] len, input logic [7:0] rxv);
      @(negedge C100M);
      new_rx_length = len;
      set_rx_length = 1'b1;
      for (int i = 0; i < int'(len); i++) begin
         exp_mosi.push_back(8'hFF);
         exp_rx.push_back(rxv);
      end
      @(negedge C100M);
      set_rx_length = 1'b0;
   endtask

   initial begin
      int base_a;
      int base_b;
      int base_c;
      int n;
      clk_div       = 8'd0;
      mode          = 2'd0;
      new_rx_length = 13'd0;
      set_rx_length = 1'b0;
      wr_req        = 1'b0;
      data_in       = 8'h00;

      // reset state
      #12;
      chk("rst_sclk", SCLK, 1'b0);
      chk("rst_mosi", MOSI, 1'b1);
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_in_full", in_full, 1'b0);
      chk("rst_out_full", out_full, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(negedge C100M);
      RESET_n = 1'b1;

      // write-only, fastest clock: 20-unit SCLK period, 8 rises, no RX byte
      base_a   = rises_total;
      base_b   = n_int;
      base_c   = n_bad_int;
      per_exp  = 20;
      track_id = 1;
      write_byte(8'hA5, 1'b0);
      wait_idle(100);
      chk("t1_rises", rises_total - base_a, 8);
      chk("t1_periods", n_int - base_b, 7);
      chk("t1_bad_period", n_bad_int - base_c, 0);
      chk("t1_sclk_low", SCLK, 1'b0);
      chk("t1_out_full", out_full, 1'b0);
      track_id = 0;

      // full duplex, slowest clock: data_out after 16*256 cycles
      clk_div    = 8'd255;
      mode       = 2'd2;
      slave_byte = 8'h3C;
      base_b     = n_int;
      base_c     = n_bad_int;
      per_exp    = 5120;
      track_id   = 2;
      write_byte(8'h5A, 1'b1);
      n = 0;
      @(posedge C100M); #1;
      while (in_full && n < 10) begin
         @(posedge C100M); #1;
         n++;
      end
      n = 0;
      while (!out_full && n < 10000) begin
         @(posedge C100M); #1;
         n++;
      end
      chk("t2_latency", n, 4096);
      chk("t2_out_full", out_full, 1'b1);
      chk("t2_periods", n_int - base_b, 7);
      chk("t2_bad_period", n_bad_int - base_c, 0);
      track_id = 0;
      req_tok++;
      wait_out_full(1'b0, 20);
      wait_idle(20);

      // autonomous read of 3 bytes with a consumer that always reads
      clk_div    = 8'd0;
      mode       = 2'd1;
      slave_byte = 8'hC3;
      auto_rd    = 1'b1;
      base_a     = n_reads;
      set_length(13'd3, 8'hC3);
      wait_idle(500);
      wait_out_full(1'b0, 20);
      chk("t3_reads", n_reads - base_a, 3);
      chk("t3_mosi_idle", MOSI, 1'b1);
      chk("t3_busy", busy, 1'b0);
      auto_rd = 1'b0;

      // autonomous read of 2 bytes, consumer stalls after the first
      slave_byte = 8'h81;
      base_a     = rises_total;
      set_length(13'd2, 8'h81);
      wait_out_full(1'b1, 200);
      repeat (20) @(negedge C100M);
      chk("t4_stall_sclk", SCLK, 1'b0);
      chk("t4_stall_mosi", MOSI, 1'b1);
      chk("t4_stall_busy", busy, 1'b1);
      chk("t4_stall_rises", rises_total - base_a, 8);
      req_tok++;
      n = 0;
      @(posedge C100M); #1;
      while (!rd_req && n < 10) begin
         @(posedge C100M); #1;
         n++;
      end
      @(posedge C100M); #1;
      chk("t4_restart_sclk", SCLK, 1'b1);
      wait_out_full(1'b1, 200);
      req_tok++;
      wait_out_full(1'b0, 20);
      wait_idle(20);
      chk("t4_rises", rises_total - base_a, 16);
      mode = 2'd0;

      // two back-to-back writes: continuous SCLK across the byte boundary
      clk_div  = 8'd1;
      base_a   = n_infull_falls;
      base_b   = n_int;
      base_c   = n_bad_int;
      per_exp  = 40;
      track_id = 5;
      write_byte(8'h11, 1'b0);
      write_byte(8'hE7, 1'b0);
      wait_idle(200);
      chk("t5_periods", n_int - base_b, 15);
      chk("t5_bad_period", n_bad_int - base_c, 0);
      chk("t5_in_full_falls", n_infull_falls - base_a, 2);
      track_id = 0;

      // reset in the middle of a byte, then a clean reserved-mode byte
      clk_div = 8'd3;
      base_a  = rises_total;
      write_byte(8'h96, 1'b0);
      write_byte(8'h0F, 1'b0);
      n = 0;
      while ((rises_total - base_a) < 4 && n < 500) begin
         @(negedge C100M);
         n++;
      end
      chk("t6_reached_bit4", rises_total - base_a, 4);
      #1;
      RESET_n = 1'b0;
      exp_mosi.delete();
      #1;
      chk("t6_sclk", SCLK, 1'b0);
      chk("t6_mosi", MOSI, 1'b1);
      chk("t6_in_full", in_full, 1'b0);
      chk("t6_out_full", out_full, 1'b0);
      chk("t6_data_out", data_out, 8'h00);
      chk("t6_busy", busy, 1'b0);
      repeat (3) @(negedge C100M);
      RESET_n = 1'b1;
      mode    = 2'd3;
      base_a  = rises_total;
      write_byte(8'h3C, 1'b0);
      wait_idle(200);
      chk("t6_rises", rises_total - base_a, 8);
      chk("t6_out_full_after", out_full, 1'b0);

      repeat (4) @(negedge C100M);
      chk("mosi_queue_empty", exp_mosi.size(), 0);
      chk("rx_queue_empty", exp_rx.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
